fib_requester: RTL and testbench

- Initiator for the fib engine's strobe/busy request interface.
- Accepts a batch command (start index N, count C) from a host, then issues C sequential requests to the engine for N, N+1, …, N+C-1.
- For each request it waits for completion, captures the engine result and presents it on a valid/ready result stream with index, cycle count, last and error flags.
- Sits between the host control logic and one fib engine instance; both share clock and reset.

---
 rtl/fib_requester.sv | 138 +++++++++++++
 tb/tb_fib_requester.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fib_requester.sv
// Batch initiator for the fib engine strobe/busy interface: issues N..N+C-1 one
// request at a time and returns each captured result on a valid/ready stream.
module fib_requester #(
  parameter int WIDTH   = 32,
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 1024,
  parameter int CYC_W   = 16
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_cmd_valid,
  output logic             o_cmd_ready,
  input  logic [WIDTH-1:0] i_cmd_n,
  input  logic [CNT_W-1:0] i_cmd_count,
  output logic             o_eng_stb,
  output logic [WIDTH-1:0] o_eng_n,
  input  logic             i_eng_busy,
  input  logic [WIDTH-1:0] i_eng_fib,
  output logic             o_res_valid,
  input  logic             i_res_ready,
  output logic [WIDTH-1:0] o_res_n,
  output logic [WIDTH-1:0] o_res_fib,
  output logic [CYC_W-1:0] o_res_cycles,
  output logic             o_res_last,
  output logic             o_res_err,
  output logic             o_busy
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ISSUE  = 3'd1;
  localparam logic [2:0] S_SETTLE = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_HOLD   = 3'd4;

  localparam int TO_W = $clog2(TIMEOUT) + 1;
  localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT - 1);
  localparam logic [CYC_W-1:0] CYC_MAX = {CYC_W{1'b1}};

  logic [2:0]       r_state;
  logic [WIDTH-1:0] r_idx;
  logic [CNT_W-1:0] r_rem;
  logic [CYC_W-1:0] r_cyc;
  logic [TO_W-1:0]  r_tcnt;
  logic [WIDTH-1:0] r_res_n;
  logic [WIDTH-1:0] r_res_fib;
  logic [CYC_W-1:0] r_res_cycles;
  logic             r_res_last;
  logic             r_res_err;

  logic [CYC_W-1:0] w_cyc_inc;
  logic             w_idle;

  assign w_cyc_inc    = (r_cyc == CYC_MAX) ? r_cyc : r_cyc + CYC_W'(1);
  assign w_idle       = (r_state == S_IDLE);

  assign o_cmd_ready  = w_idle;
  assign o_busy       = !w_idle;
  assign o_eng_stb    = (r_state == S_ISSUE) && !i_eng_busy;
  assign o_eng_n      = w_idle ? {WIDTH{1'b0}} : r_idx;
  assign o_res_valid  = (r_state == S_HOLD);
  assign o_res_n      = r_res_n;
  assign o_res_fib    = r_res_fib;
  assign o_res_cycles = r_res_cycles;
  assign o_res_last   = r_res_last;
  assign o_res_err    = r_res_err;

  // Request sequencer: state, batch bookkeeping and result capture.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= S_IDLE;
      r_idx        <= {WIDTH{1'b0}};
      r_rem        <= {CNT_W{1'b0}};
      r_cyc        <= {CYC_W{1'b0}};
      r_tcnt       <= {TO_W{1'b0}};
      r_res_n      <= {WIDTH{1'b0}};
      r_res_fib    <= {WIDTH{1'b0}};
      r_res_cycles <= {CYC_W{1'b0}};
      r_res_last   <= 1'b0;
      r_res_err    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_cmd_valid) begin
            r_idx   <= i_cmd_n;
            r_rem   <= (i_cmd_count == {CNT_W{1'b0}}) ? CNT_W'(1) : i_cmd_count;
            r_state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (!i_eng_busy) begin
            r_cyc   <= CYC_W'(1);
            r_tcnt  <= {TO_W{1'b0}};
            r_state <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          // The timeout window spans SETTLE and WAIT together.
          r_cyc   <= w_cyc_inc;
          r_tcnt  <= r_tcnt + TO_W'(1);
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (!i_eng_busy) begin
            r_res_n      <= r_idx;
            r_res_fib    <= i_eng_fib;
            r_res_cycles <= w_cyc_inc;
            r_res_last   <= (r_rem == CNT_W'(1));
            r_res_err    <= 1'b0;
            r_state      <= S_HOLD;
          end else if (r_tcnt >= TO_LAST) begin
            r_res_n      <= r_idx;
            r_res_fib    <= i_eng_fib;
            r_res_cycles <= w_cyc_inc;
            r_res_last   <= 1'b1;
            r_res_err    <= 1'b1;
            r_state      <= S_HOLD;
          end else begin
            r_cyc  <= w_cyc_inc;
            r_tcnt <= r_tcnt + TO_W'(1);
          end
        end
        S_HOLD: begin
          if (i_res_ready) begin
            if (r_res_last) begin
              r_state <= S_IDLE;
            end else begin
              r_idx   <= r_idx + WIDTH'(1);
              r_rem   <= r_rem - CNT_W'(1);
              r_state <= S_ISSUE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fib_requester.sv
// Directed bench for fib_requester with a small engine stub
// (busy n cycles after the strobe, capped at 2 for n > 20; result n+100).
module tb_fib_requester;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [31:0] cmd_n = 32'd0;
  logic [7:0]  cmd_count = 8'd0;
  logic        eng_stb;
  logic [31:0] eng_n;
  logic        eng_busy;
  logic [31:0] eng_fib;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [31:0] res_n;
  logic [31:0] res_fib;
  logic [15:0] res_cycles;
  logic        res_last;
  logic        res_err;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  fib_requester #(.WIDTH(32), .CNT_W(8), .TIMEOUT(16), .CYC_W(16)) dut (
    .i_clk(clk), .i_reset(reset),
    .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready),
    .i_cmd_n(cmd_n), .i_cmd_count(cmd_count),
    .o_eng_stb(eng_stb), .o_eng_n(eng_n),
    .i_eng_busy(eng_busy), .i_eng_fib(eng_fib),
    .o_res_valid(res_valid), .i_res_ready(res_ready),
    .o_res_n(res_n), .o_res_fib(res_fib), .o_res_cycles(res_cycles),
    .o_res_last(res_last), .o_res_err(res_err), .o_busy(busy)
  );

  always #5 clk = ~clk;

  // Engine stub; stick_mode keeps busy asserted after the strobe until cleared.
  logic [31:0] stub_cnt = 32'd0;
  logic [31:0] stub_fib = 32'd0;
  logic        stub_hold = 1'b0;
  logic        stick_mode = 1'b0;
  assign eng_busy = (stub_cnt != 32'd0) || stub_hold;
  assign eng_fib  = stub_fib;

  always @(posedge clk) begin
    if (reset) begin
      stub_cnt  <= 32'd0;
      stub_fib  <= 32'd0;
      stub_hold <= 1'b0;
    end else if (eng_stb) begin
      stub_cnt  <= (eng_n > 32'd20) ? 32'd2 : eng_n;
      stub_fib  <= eng_n + 32'd100;
      stub_hold <= stick_mode;
    end else begin
      if (stub_cnt != 32'd0) stub_cnt <= stub_cnt - 32'd1;
      if (!stick_mode) stub_hold <= 1'b0;
    end
  end

  int          stb_total = 0;
  logic [31:0] last_stb_n = 32'd0;
  always @(negedge clk) begin
    if (eng_stb) begin
      stb_total  <= stb_total + 1;
      last_stb_n <= eng_n;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents a command in cycle 0; returns in cycle 1.
  task automatic send_cmd(input logic [31:0] n, input logic [7:0] c);
    cmd_n = n; cmd_count = c; cmd_valid = 1'b1;
    n_tests++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL cmd_ready_idle: got %b want 1", cmd_ready); end
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 1;
    while (!res_valid && lat < 200) begin
      step();
      lat++;
    end
    n_tests++; if (res_valid !== 1'b1) begin n_fail++; $display("FAIL wait_valid: no result within %0d cycles", lat); end
  endtask

  task automatic test_reset();
    n_tests++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rst_cmd_ready: got %b want 1", cmd_ready); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_tests++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", res_valid); end
    n_tests++; if (eng_stb !== 1'b0) begin n_fail++; $display("FAIL rst_stb: got %b want 0", eng_stb); end
    n_tests++; if ({res_n, res_fib, res_cycles, res_last, res_err, eng_n} !== 114'd0) begin n_fail++; $display("FAIL rst_fields: n=%0d fib=%0d cyc=%0d last=%b err=%b eng_n=%0d want all 0", res_n, res_fib, res_cycles, res_last, res_err, eng_n); end
  endtask

  task automatic test_single();
    int lat, s0;
    s0 = stb_total;
    res_ready = 1'b1;
    send_cmd(32'd5, 8'd1);
    wait_valid(lat);
    n_tests++; if (lat != 8) begin n_fail++; $display("FAIL single_latency: got %0d want 8", lat); end
    n_tests++; if (res_fib !== 32'd105) begin n_fail++; $display("FAIL single_fib: got %0d want 105", res_fib); end
    n_tests++; if (res_cycles !== 16'd7) begin n_fail++; $display("FAIL single_cycles: got %0d want 7", res_cycles); end
    n_tests++; if ({res_last, res_err} !== 2'b10) begin n_fail++; $display("FAIL single_flags: got last=%b err=%b want 1/0", res_last, res_err); end
    n_tests++; if (res_n !== 32'd5) begin n_fail++; $display("FAIL single_n: got %0d want 5", res_n); end
    step();
    n_tests++; if (cmd_ready !== 1'b1 || res_valid !== 1'b0) begin n_fail++; $display("FAIL single_idle_c9: got ready=%b valid=%b want 1/0", cmd_ready, res_valid); end
    n_tests++; if (stb_total - s0 != 1 || last_stb_n !== 32'd5) begin n_fail++; $display("FAIL single_strobe: got %0d strobes n=%0d want 1 n=5", stb_total - s0, last_stb_n); end
    res_ready = 1'b0;
  endtask

  task automatic test_zero_index();
    int lat;
    res_ready = 1'b1;
    send_cmd(32'd0, 8'd1);
    wait_valid(lat);
    n_tests++; if (lat != 4) begin n_fail++; $display("FAIL zero_latency: got %0d want 4", lat); end
    n_tests++; if (res_fib !== 32'd100 || res_cycles !== 16'd3 || res_last !== 1'b1) begin n_fail++; $display("FAIL zero_result: got fib=%0d cyc=%0d last=%b want 100/3/1", res_fib, res_cycles, res_last); end
    step();
    res_ready = 1'b0;
  endtask

  task automatic test_count_zero();
    int lat, s0;
    s0 = stb_total;
    res_ready = 1'b1;
    send_cmd(32'd7, 8'd0);
    wait_valid(lat);
    n_tests++; if (res_fib !== 32'd107 || res_last !== 1'b1 || res_cycles !== 16'd9) begin n_fail++; $display("FAIL count0_result: got fib=%0d last=%b cyc=%0d want 107/1/9", res_fib, res_last, res_cycles); end
    step();
    n_tests++; if (cmd_ready !== 1'b1 || stb_total - s0 != 1) begin n_fail++; $display("FAIL count0_single: got ready=%b strobes=%0d want 1/1", cmd_ready, stb_total - s0); end
    res_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    int lat, s0;
    int hold_c [4] = '{0, 1, 2, 0};
    logic [31:0] fib_snap;
    s0 = stb_total;
    res_ready = 1'b0;
    send_cmd(32'd3, 8'd4);
    for (int i = 0; i < 4; i++) begin
      wait_valid(lat);
      n_tests++; if (res_n !== 32'(3 + i) || res_fib !== 32'(103 + i)) begin n_fail++; $display("FAIL b2b_result%0d: got n=%0d fib=%0d want %0d/%0d", i, res_n, res_fib, 3 + i, 103 + i); end
      n_tests++; if (res_cycles !== 16'(5 + i) || res_last !== (i == 3) || res_err !== 1'b0) begin n_fail++; $display("FAIL b2b_meta%0d: got cyc=%0d last=%b err=%b want %0d/%0d/0", i, res_cycles, res_last, res_err, 5 + i, i == 3); end
      fib_snap = res_fib;
      cmd_valid = 1'b1; cmd_n = 32'd50; cmd_count = 8'd1;
      for (int h = 0; h < hold_c[i]; h++) begin
        step();
        n_tests++; if (res_valid !== 1'b1 || res_fib !== fib_snap || cmd_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_hold%0d: got valid=%b fib=%0d ready=%b want 1/%0d/0", i, res_valid, res_fib, cmd_ready, fib_snap); end
      end
      cmd_valid = 1'b0;
      res_ready = 1'b1;
      step();
      res_ready = 1'b0;
    end
    n_tests++; if (stb_total - s0 != 4 || busy !== 1'b0) begin n_fail++; $display("FAIL b2b_strobes: got %0d strobes busy=%b want 4/0", stb_total - s0, busy); end
  endtask

  task automatic test_wrap();
    int lat;
    send_cmd(32'hFFFF_FFFF, 8'd2);
    wait_valid(lat);
    n_tests++; if (res_n !== 32'hFFFF_FFFF || res_fib !== 32'd99 || res_cycles !== 16'd4 || res_last !== 1'b0) begin n_fail++; $display("FAIL wrap_first: got n=%0h fib=%0d cyc=%0d last=%b want ffffffff/99/4/0", res_n, res_fib, res_cycles, res_last); end
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    wait_valid(lat);
    n_tests++; if (res_n !== 32'd0 || res_fib !== 32'd100 || res_last !== 1'b1 || last_stb_n !== 32'd0) begin n_fail++; $display("FAIL wrap_second: got n=%0d fib=%0d last=%b stb_n=%0d want 0/100/1/0", res_n, res_fib, res_last, last_stb_n); end
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
  endtask

  task automatic test_timeout();
    int lat, s0;
    stick_mode = 1'b1;
    send_cmd(32'd2, 8'd3);
    wait_valid(lat);
    n_tests++; if (lat != 18) begin n_fail++; $display("FAIL to_latency: got %0d want 18", lat); end
    n_tests++; if (res_err !== 1'b1 || res_last !== 1'b1 || res_cycles !== 16'd17 || res_n !== 32'd2) begin n_fail++; $display("FAIL to_result: got err=%b last=%b cyc=%0d n=%0d want 1/1/17/2", res_err, res_last, res_cycles, res_n); end
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    n_tests++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL to_abort_idle: got ready=%b want 1", cmd_ready); end
    s0 = stb_total;
    send_cmd(32'd4, 8'd1);
    repeat (10) step();
    n_tests++; if (stb_total != s0 || busy !== 1'b1 || res_valid !== 1'b0) begin n_fail++; $display("FAIL to_stall_issue: got strobes=%0d busy=%b valid=%b want 0/1/0", stb_total - s0, busy, res_valid); end
    stick_mode = 1'b0;
    wait_valid(lat);
    n_tests++; if (res_fib !== 32'd104 || res_err !== 1'b0 || res_cycles !== 16'd6 || stb_total - s0 != 1) begin n_fail++; $display("FAIL to_recover: got fib=%0d err=%b cyc=%0d strobes=%0d want 104/0/6/1", res_fib, res_err, res_cycles, stb_total - s0); end
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
  endtask

  task automatic test_mid_reset();
    int lat;
    send_cmd(32'd10, 8'd4);
    repeat (4) step();
    n_tests++; if (busy !== 1'b1 || eng_busy !== 1'b1) begin n_fail++; $display("FAIL mrst_inwait: got busy=%b eng_busy=%b want 1/1", busy, eng_busy); end
    reset = 1'b1;
    step();
    n_tests++; if (busy !== 1'b0 || res_valid !== 1'b0 || cmd_ready !== 1'b1) begin n_fail++; $display("FAIL mrst_state: got busy=%b valid=%b ready=%b want 0/0/1", busy, res_valid, cmd_ready); end
    cmd_valid = 1'b1; cmd_n = 32'd9; cmd_count = 8'd1;
    step();
    reset = 1'b0; cmd_valid = 1'b0;
    step();
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mrst_cmd_dropped: got busy=%b want 0", busy); end
    res_ready = 1'b1;
    send_cmd(32'd1, 8'd1);
    wait_valid(lat);
    n_tests++; if (lat != 4 || res_fib !== 32'd101 || res_cycles !== 16'd3 || res_last !== 1'b1) begin n_fail++; $display("FAIL mrst_after: got lat=%0d fib=%0d cyc=%0d last=%b want 4/101/3/1", lat, res_fib, res_cycles, res_last); end
    step();
    res_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    step();
    step();
    test_reset();
    reset = 1'b0;
    step();
    test_single();
    test_zero_index();
    test_count_zero();
    test_back_to_back();
    test_wrap();
    test_timeout();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
